// File: rtl/seq_control_unit_if.sv
// Instruction-fetch handshake between the control unit (master) and the
// program store (slave).
interface seq_control_unit_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4
);
  localparam int INSTR_W = 4 + 2*DATA_W;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               imem_valid;

  modport master (output imem_req, imem_addr, input imem_data, imem_valid);
  modport slave  (input imem_req, imem_addr, output imem_data, imem_valid);
endinterface

// File: rtl/seq_control_unit.sv
// Multi-cycle control unit: fetches, decodes and executes a whole program
// with its own register file, flag register, ALU and branch logic.
module seq_control_unit #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  seq_control_unit_if.master      imem,
  output logic                    halted,
  output logic [2:0]              cpu_state,
  output logic [PC_W-1:0]         pc_out,
  output logic [3:0]              flags,
  output logic [NREGS*DATA_W-1:0] reg_file_out
);
  localparam int RIDX_W  = $clog2(NREGS);
  localparam int INSTR_W = 4 + 2*DATA_W;
  localparam int MSB     = DATA_W - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDR  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_MOV  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JNZ  = 4'hA,
    OP_JC   = 4'hB,
    OP_CMP  = 4'hC,
    OP_STOP = 4'hF
  } opcode_t;

  state_t               state, next_state;
  logic [PC_W-1:0]      pc;
  logic [INSTR_W-1:0]   ir;
  logic [DATA_W-1:0]    regs [NREGS];
  logic [3:0]           flags_q;
  logic [DATA_W-1:0]    alu_a, alu_b;

  logic [3:0]           opcode;
  logic [RIDX_W-1:0]    rd, rs;
  logic [DATA_W-1:0]    imm;
  logic [PC_W-1:0]      target;
  logic                 unused_op1;

  logic [DATA_W:0]      sum, diff;
  logic [DATA_W-1:0]    alu_res, wr_data;
  logic                 alu_c, alu_v, write_en, flag_en, jump_en;
  logic [3:0]           new_flags;

  assign opcode     = ir[INSTR_W-1 -: 4];
  assign rd         = ir[DATA_W +: RIDX_W];
  assign rs         = ir[0 +: RIDX_W];
  assign imm        = ir[DATA_W-1:0];
  assign target     = ir[DATA_W +: PC_W];
  assign unused_op1 = ^ir[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_FETCH;
      S_FETCH:   if (imem.imem_valid) next_state = S_DECODE;
      S_DECODE:  next_state = (opcode == OP_STOP) ? S_HALT : S_EXECUTE;
      S_EXECUTE: next_state = S_FETCH;
      S_HALT:    if (start) next_state = S_FETCH;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state == S_FETCH);
    imem.imem_addr = pc;
    halted         = (state == S_HALT);
    cpu_state      = state;
    pc_out         = pc;
    flags          = flags_q;
  end

  // Operates on the operands latched in DECODE, so the register file can be
  // written in EXECUTE without disturbing the values being combined.
  always_comb begin
    sum      = {1'b0, alu_a} + {1'b0, alu_b};
    diff     = {1'b0, alu_a} - {1'b0, alu_b};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    wr_data  = '0;
    write_en = 1'b0;
    flag_en  = 1'b0;
    jump_en  = 1'b0;
    case (opcode)
      OP_LDR: begin
        write_en = 1'b1;
        wr_data  = imm;
      end
      OP_ADD: begin
        alu_res  = sum[DATA_W-1:0];
        alu_c    = sum[DATA_W];
        alu_v    = (alu_a[MSB] == alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
        wr_data  = alu_res;
        write_en = 1'b1;
        flag_en  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res  = diff[DATA_W-1:0];
        alu_c    = diff[DATA_W];
        alu_v    = (alu_a[MSB] != alu_b[MSB]) && (alu_res[MSB] != alu_a[MSB]);
        wr_data  = alu_res;
        write_en = (opcode == OP_SUB);
        flag_en  = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR: begin
        alu_res  = (opcode == OP_AND) ? (alu_a & alu_b) :
                   (opcode == OP_OR)  ? (alu_a | alu_b) : (alu_a ^ alu_b);
        wr_data  = alu_res;
        write_en = 1'b1;
        flag_en  = 1'b1;
      end
      OP_MOV: begin
        wr_data  = alu_b;
        write_en = 1'b1;
      end
      OP_JMP:  jump_en = 1'b1;
      OP_JZ:   jump_en = flags_q[0];
      OP_JNZ:  jump_en = ~flags_q[0];
      OP_JC:   jump_en = flags_q[2];
      default: ;
    endcase
    new_flags = {alu_v, alu_c, alu_res[MSB], ~|alu_res};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      flags_q <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (imem.imem_valid) begin
          ir <= imem.imem_data;
          pc <= pc + PC_W'(1);
        end
        S_DECODE: begin
          alu_a <= regs[rd];
          alu_b <= regs[rs];
        end
        S_EXECUTE: begin
          if (write_en) regs[rd] <= wr_data;
          if (flag_en)  flags_q  <= new_flags;
          if (jump_en)  pc       <= target;
        end
        S_HALT: if (start) pc <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_file_out = '0;
    for (int i = 0; i < NREGS; i++) reg_file_out[i*DATA_W +: DATA_W] = regs[i];
  end
endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit: directed and random programs run
// against an instruction-level interpreter of the ISA.
module tb_seq_control_unit;
  localparam int DATA_W  = 8;
  localparam int NREGS   = 8;
  localparam int PC_W    = 4;
  localparam int INSTR_W = 4 + 2*DATA_W;
  localparam int PSIZE   = 1 << PC_W;
  localparam int DMOD    = 1 << DATA_W;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    halted;
  logic [2:0]              cpu_state;
  logic [PC_W-1:0]         pc_out;
  logic [3:0]              flags;
  logic [NREGS*DATA_W-1:0] reg_file_out;

  seq_control_unit_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

  seq_control_unit #(.DATA_W(DATA_W), .NREGS(NREGS), .PC_W(PC_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem         (bus),
    .halted       (halted),
    .cpu_state    (cpu_state),
    .pc_out       (pc_out),
    .flags        (flags),
    .reg_file_out (reg_file_out)
  );

  always #5 clk = ~clk;

  logic [INSTR_W-1:0] prog [PSIZE];
  assign bus.imem_data = prog[bus.imem_addr];

  int checks = 0, passed = 0, failed = 0;

  int              max_wait = 0, wait_left = 0, total_waits = 0, addr_changes = 0;
  bit              hold_low = 1'b0, in_wait = 1'b0;
  logic [PC_W-1:0] wait_addr;
  logic [PC_W-1:0] fetch_log [$];

  int         m_regs [NREGS];
  logic [3:0] m_flags;
  int         m_pc;
  bit         m_halted;

  // Program store: answers each request after a random number of wait cycles
  // and logs every address it accepts.
  initial begin
    bus.imem_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.imem_req && !hold_low) begin
        if (in_wait && bus.imem_addr !== wait_addr) addr_changes++;
        if (wait_left == 0) begin
          bus.imem_valid = 1'b1;
          in_wait = 1'b0;
          fetch_log.push_back(bus.imem_addr);
          wait_left = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
        end else begin
          bus.imem_valid = 1'b0;
          in_wait = 1'b1;
          wait_addr = bus.imem_addr;
          wait_left--;
          total_waits++;
        end
      end else begin
        bus.imem_valid = 1'b0;
        in_wait = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [INSTR_W-1:0] ins(input int op, input int a, input int b);
    return {op[3:0], a[DATA_W-1:0], b[DATA_W-1:0]};
  endfunction

  task automatic clearProg();
    for (int i = 0; i < PSIZE; i++) prog[i] = ins(0, 0, 0);
  endtask

  task automatic modelReset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
    m_flags  = 4'b0;
    m_pc     = 0;
    m_halted = 1'b0;
  endtask

  function automatic logic [NREGS*DATA_W-1:0] modelRegs();
    logic [NREGS*DATA_W-1:0] v = '0;
    for (int i = 0; i < NREGS; i++) v[i*DATA_W +: DATA_W] = m_regs[i][DATA_W-1:0];
    return v;
  endfunction

  function automatic bit ovf(input int x);
    return (x > DMOD/2 - 1) || (x < -(DMOD/2));
  endfunction

  task automatic setFlags(input int r, input bit c, input bit v);
    m_flags = {v, c, r >= DMOD/2, r == 0};
  endtask

  // Instruction-level interpreter; returns the number of instructions
  // executed before STOP.
  task automatic modelRun(output int steps);
    logic [INSTR_W-1:0] w;
    int opc, o1, o2, d, s, a, b, r, sa, sb;
    if (m_halted) m_pc = 0;
    m_halted = 1'b0;
    steps = 0;
    for (int n = 0; n < 200; n++) begin
      w = prog[m_pc];
      m_pc = (m_pc + 1) % PSIZE;
      opc = int'(w[INSTR_W-1 -: 4]);
      o1  = int'(w[2*DATA_W-1:DATA_W]);
      o2  = int'(w[DATA_W-1:0]);
      if (opc == 15) begin
        m_halted = 1'b1;
        break;
      end
      steps++;
      d  = o1 % NREGS;
      s  = o2 % NREGS;
      a  = m_regs[d];
      b  = m_regs[s];
      sa = (a >= DMOD/2) ? a - DMOD : a;
      sb = (b >= DMOD/2) ? b - DMOD : b;
      case (opc)
        1: m_regs[d] = o2;
        2: begin
          r = a + b;
          m_regs[d] = r % DMOD;
          setFlags(r % DMOD, r >= DMOD, ovf(sa + sb));
        end
        3, 12: begin
          r = (a - b + DMOD) % DMOD;
          if (opc == 3) m_regs[d] = r;
          setFlags(r, a < b, ovf(sa - sb));
        end
        4: begin m_regs[d] = a & b; setFlags(a & b, 1'b0, 1'b0); end
        5: begin m_regs[d] = a | b; setFlags(a | b, 1'b0, 1'b0); end
        6: begin m_regs[d] = a ^ b; setFlags(a ^ b, 1'b0, 1'b0); end
        7: m_regs[d] = b;
        8: m_pc = o1 % PSIZE;
        9: if (m_flags[0]) m_pc = o1 % PSIZE;
        10: if (!m_flags[0]) m_pc = o1 % PSIZE;
        11: if (m_flags[2]) m_pc = o1 % PSIZE;
        default: ;
      endcase
    end
  endtask

  task automatic runProgram(input string tag, input int mw, output int cycles);
    int steps;
    max_wait = mw;
    wait_left = 0;
    total_waits = 0;
    addr_changes = 0;
    fetch_log.delete();
    modelRun(steps);
    applyStimulus();
    cycles = 0;
    while (!halted && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, " halted"}, 64'(halted), 64'd1);
    checkOutput({tag, " regs"}, 64'(reg_file_out), 64'(modelRegs()));
    checkOutput({tag, " flags"}, 64'(flags), 64'(m_flags));
    checkOutput({tag, " pc"}, 64'(pc_out), 64'(m_pc));
    checkOutput({tag, " cycles"}, 64'(cycles), 64'(3*steps + 2 + total_waits));
    if (mw > 0) checkOutput({tag, " addr stable"}, 64'(addr_changes), 64'd0);
  endtask

  task automatic genRandomProg();
    int opc, tgt;
    for (int i = 0; i < PSIZE - 1; i++) begin
      opc = int'($urandom_range(14, 0));
      if (opc >= 8 && opc <= 11) begin
        tgt = int'($urandom_range(PSIZE - 1, i + 1));
        prog[i] = ins(opc, (int'($urandom_range(15, 0)) << PC_W) | tgt,
                      int'($urandom_range(255, 0)));
      end else begin
        prog[i] = ins(opc, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)));
      end
    end
    prog[PSIZE-1] = ins(15, 0, 0);
  endtask

  function automatic int countFetches(input int addr);
    int n = 0;
    foreach (fetch_log[i]) if (int'(fetch_log[i]) == addr) n++;
    return n;
  endfunction

  initial begin
    int  cycles;
    bit  swapped;
    clearProg();
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("reset state", 64'(cpu_state), 64'd0);
    checkOutput("reset req", 64'(bus.imem_req), 64'd0);
    checkOutput("reset halted", 64'(halted), 64'd0);
    checkOutput("reset pc", 64'(pc_out), 64'd0);
    checkOutput("reset regs", 64'(reg_file_out), 64'd0);
    checkOutput("reset flags", 64'(flags), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle waits", 64'(cpu_state), 64'd0);

    clearProg();
    prog[0] = ins(1, 1, 5);
    prog[1] = ins(1, 2, 3);
    prog[2] = ins(2, 1, 2);
    prog[3] = ins(15, 0, 0);
    runProgram("progA", 0, cycles);
    checkOutput("progA r1", 64'(reg_file_out[15:8]), 64'd8);
    checkOutput("progA flags", 64'(flags), 64'd0);
    checkOutput("progA cycles", 64'(cycles), 64'd11);
    checkOutput("progA pc", 64'(pc_out), 64'd4);

    clearProg();
    prog[0] = ins(1, 0, 8'h80);
    prog[1] = ins(1, 1, 8'h80);
    prog[2] = ins(2, 0, 1);
    prog[3] = ins(15, 0, 0);
    runProgram("addovf", 0, cycles);
    checkOutput("addovf r0", 64'(reg_file_out[7:0]), 64'd0);
    checkOutput("addovf flags", 64'(flags), 64'b1101);

    clearProg();
    prog[0] = ins(1, 2, 1);
    prog[1] = ins(1, 3, 2);
    prog[2] = ins(12, 2, 3);
    prog[3] = ins(15, 0, 0);
    runProgram("cmp", 0, cycles);
    checkOutput("cmp flags", 64'(flags), 64'b0110);
    checkOutput("cmp r2", 64'(reg_file_out[23:16]), 64'd1);
    checkOutput("cmp r1 kept", 64'(reg_file_out[15:8]), 64'h80);

    clearProg();
    prog[0] = ins(1, 0, 3);
    prog[1] = ins(1, 1, 1);
    prog[2] = ins(3, 0, 1);
    prog[3] = ins(10, 2, 0);
    prog[4] = ins(15, 0, 0);
    for (int k = 0; k < 2; k++) begin
      runProgram(k == 0 ? "loop0" : "loopw", 3*k, cycles);
      checkOutput("loop r0", 64'(reg_file_out[7:0]), 64'd0);
      checkOutput("loop Z", 64'(flags[0]), 64'd1);
      checkOutput("loop sub count", 64'(countFetches(2)), 64'd3);
    end

    for (int k = 0; k < 4; k++) begin
      genRandomProg();
      runProgram("rand0", 0, cycles);
      runProgram("randw", 3, cycles);
    end

    hold_low = 1'b1;
    applyStimulus();
    repeat (3) @(negedge clk);
    checkOutput("stall state", 64'(cpu_state), 64'd1);
    checkOutput("stall req", 64'(bus.imem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset req", 64'(bus.imem_req), 64'd0);
    checkOutput("midreset state", 64'(cpu_state), 64'd0);
    checkOutput("midreset pc", 64'(pc_out), 64'd0);
    checkOutput("midreset regs", 64'(reg_file_out), 64'd0);
    checkOutput("midreset flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_low = 1'b0;
    modelReset();

    clearProg();
    max_wait = 0;
    wait_left = 0;
    fetch_log.delete();
    applyStimulus();
    cycles = 0;
    swapped = 1'b0;
    while (!halted && cycles < 400) begin
      @(negedge clk);
      cycles++;
      start = !halted && ($urandom_range(3, 0) == 0);
      if (!swapped && fetch_log.size() >= 18) begin
        prog[3] = ins(15, 0, 0);
        swapped = 1'b1;
      end
    end
    start = 1'b0;
    checkOutput("wrap halted", 64'(halted), 64'd1);
    checkOutput("wrap fetch count", 64'(fetch_log.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      checkOutput($sformatf("wrap addr %0d", i), 64'(fetch_log[i]), 64'(i % PSIZE));
    checkOutput("wrap pc", 64'(pc_out), 64'd4);

    fetch_log.delete();
    applyStimulus();
    cycles = 0;
    while (!halted && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("restart halted", 64'(halted), 64'd1);
    checkOutput("restart first addr", 64'(fetch_log[0]), 64'd0);
    checkOutput("restart fetch count", 64'(fetch_log.size()), 64'd4);
    checkOutput("restart pc", 64'(pc_out), 64'd4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/seq_control_unit.md
# seq_control_unit

Parametrised multi-cycle control unit that runs a full program rather than a single instruction. It fetches instructions from an external instruction memory over a request/valid handshake and loops through FETCH, DECODE and EXECUTE until STOP. It holds a parametrised register file and a flag register, contains its own ALU, and supports conditional and unconditional jumps. It sits at the top of the CPU, between the program store and the datapath, and exposes state, PC, flags and registers for debugging.

## Interface
- DATA_W, 8, datapath and register width (≥4)
- NREGS, 8, register-file entries (power of 2, ≥2); RIDX_W = clog2(NREGS)
- PC_W, 4, program-counter width; program space = 2^PC_W instructions
- INSTR_W (localparam) = 4 + 2*DATA_W; fields: opcode [INSTR_W-1 -: 4], op1 [2*DATA_W-1:DATA_W], op2 [DATA_W-1:0]

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; starts or restarts execution
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_data  in  INSTR_W  instruction word, sampled when imem_valid=1 and imem_req=1
- imem_valid  in  1  instruction word valid
- halted  out  1  high while in HALT
- cpu_state  out  3  0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 HALT
- pc_out  out  PC_W  current pc
- flags  out  4  {V, C, N, Z}
- reg_file_out  out  NREGS*DATA_W  r[NREGS-1] in the MSBs … r[0] in the LSBs

## Operation
- Opcodes: 0 NOP; 1 LDR rd,imm (r[op1] ← op2); 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR (r[op1] ← r[op1] op r[op2]); 7 MOV (r[op1] ← r[op2]); 8 JMP op1; 9 JZ op1; A JNZ op1; B JC op1; C CMP (computes r[op1]−r[op2], updates flags only); D, E reserved, executed as NOP; F STOP.
- Register indices = low RIDX_W bits of the operand. Jump target = low PC_W bits of op1. Upper bits are ignored.
- IDLE: wait for start, then go to FETCH with pc unchanged (0 after reset).
- FETCH: imem_req=1 and imem_addr=pc. Stay until imem_valid. On the valid cycle, load the IR, set pc ← pc+1 (mod 2^PC_W, wraps silently), and go to DECODE.
- DECODE: latch ALU operands A=r[op1] and B=r[op2]. If opcode=F, go to HALT; otherwise go to EXECUTE.
- EXECUTE: perform writeback, flag update and jump, then go to FETCH. A taken jump loads pc ← target, overriding the increment made in FETCH. A branch whose condition is false leaves pc unchanged.
- Flags update only on ADD, SUB, AND, OR, XOR and CMP:
  - Z = (result == 0).
  - N = result[DATA_W-1].
  - ADD: C = carry-out, V = signed overflow.
  - SUB/CMP: C = borrow (A < B unsigned), V = signed overflow.
  - Logic ops: C = 0, V = 0.
- Arithmetic is DATA_W-bit modulo; results are truncated.
- HALT: halted=1; registers and flags are held. start sets pc ← 0 and goes to FETCH. Registers and flags are preserved across the restart.
- start is ignored outside IDLE and HALT.

## Timing
- Reset (async assert, sync release): state=IDLE, pc=0, IR=0, all registers=0, flags=0, imem_req=0, halted=0. imem_req falls combinationally at assertion, including in the middle of a fetch.
- All outputs are registered or decoded from registered state. imem_req and halted are decoded from state.
- Zero-wait memory (imem_valid high in the first FETCH cycle): 3 cycles per instruction. Each wait cycle adds 1.
- imem_addr is stable while imem_req=1. imem_valid is ignored when imem_req=0.
- A register write or flag update becomes visible on reg_file_out/flags on the clock edge that leaves EXECUTE. The next instruction's DECODE sees the new values (no hazard).
- start → first imem_req: 1 cycle (the next state is FETCH).
- STOP: DECODE → HALT; halted rises 1 cycle after the STOP DECODE cycle. pc = STOP address + 1.

## Test plan
- Reset mid-FETCH (imem_valid held low): pull rst_n low → imem_req=0 immediately, state=0, pc=0, all registers and flags 0.
- Program LDR r1,5; LDR r2,3; ADD r1,r2; STOP with zero-wait memory → r1=8, flags=0000, halted after 11 cycles from start, pc=4.
- LDR r0,0x80; LDR r1,0x80; ADD r0,r1 → r0=0x00, flags {V,C,N,Z}=1101. Then CMP r2,r3 with r2=1, r3=2 → C=1, N=1, Z=0, V=0, r2 unchanged.
- Loop LDR r0,3; LDR r1,1; SUB r0,r1; JNZ 2; STOP → r0=0, Z=1, SUB executed 3 times, halted.
- Random 0–3 wait cycles on imem_valid → identical final registers to the zero-wait run; imem_addr constant during every wait.
- PC wrap (PC_W=2, four NOPs, no STOP) → fetch addresses 0,1,2,3,0,…; start pulses in FETCH ignored; start in HALT restarts fetching from address 0.
